// File: rtl/div_issue_ctrl_if.sv
// Divider handshake bundle between the EX-stage issue controller and the
// multi-cycle divider.
interface div_issue_ctrl_if;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_opdata1_o;
   logic [31:0] div_opdata2_o;
   logic [63:0] div_ret_i;
   logic        div_ready_i;

   modport master (
      output div_start_o, div_annul_o, div_signed_o,
      output div_opdata1_o, div_opdata2_o,
      input  div_ret_i, div_ready_i
   );

   modport slave (
      input  div_start_o, div_annul_o, div_signed_o,
      input  div_opdata1_o, div_opdata2_o,
      output div_ret_i, div_ready_i
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues DIV/DIVU, stalls
// while busy, writes {HI,LO} and aborts on flush or watchdog expiry.
module div_issue_ctrl #(
   parameter int WDOG_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_valid_i,
   input  logic        div_signed_i,
   input  logic [31:0] div_op1_i,
   input  logic [31:0] div_op2_i,
   input  logic        flush_i,
   output logic        stall_req_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_timeout_o,
   div_issue_ctrl_if.master div
);

   localparam int CW = $clog2(WDOG_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_start;
   logic          r_signed;
   logic [31:0]   r_op1;
   logic [31:0]   r_op2;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic          r_timeout;

   logic w_issue;
   logic w_busy;
   logic w_done;
   logic w_wdog;

   // Combinational outputs are gated by rst so everything reads 0 in reset.
   assign w_issue = rst && (r_state == S_IDLE) && div_valid_i && !flush_i;
   assign w_busy  = rst && (r_state == S_BUSY);
   assign w_done  = rst && (r_state == S_DONE);
   assign w_wdog  = (r_cnt == CW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_start   <= 1'b0;
         r_signed  <= 1'b0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_signed <= div_signed_i;
                  r_op1    <= div_op1_i;
                  r_op2    <= div_op2_i;
                  r_start  <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + CW'(1);
               if (flush_i) begin
                  r_start <= 1'b0;
                  r_state <= S_IDLE;
               end else if (div.div_ready_i) begin
                  r_hi    <= div.div_ret_i[63:32];
                  r_lo    <= div.div_ret_i[31:0];
                  r_start <= 1'b0;
                  r_state <= S_DONE;
               end else if (w_wdog) begin
                  r_start   <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stall_req_o   = w_issue || w_busy;
   assign hilo_we_o     = w_done && !flush_i;
   assign hi_o          = r_hi;
   assign lo_o          = r_lo;
   assign div_timeout_o = r_timeout;

   assign div.div_start_o   = r_start;
   assign div.div_annul_o   = w_busy && flush_i;
   assign div.div_signed_o  = r_signed;
   assign div.div_opdata1_o = r_op1;
   assign div.div_opdata2_o = r_op2;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that
// answers a fixed number of cycles after start, or never.
module tb_div_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        sgn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        flush;
   logic        stall;
   logic        we;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        tmo;

   int n_vec;
   int n_err;
   int m_cnt;
   bit m_never;

   div_issue_ctrl_if u_if ();

   div_issue_ctrl #(.WDOG_CYCLES(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .div_valid_i   (valid),
      .div_signed_i  (sgn),
      .div_op1_i     (op1),
      .div_op2_i     (op2),
      .flush_i       (flush),
      .stall_req_o   (stall),
      .hilo_we_o     (we),
      .hi_o          (hi),
      .lo_o          (lo),
      .div_timeout_o (tmo),
      .div           (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(
      input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider: ready 34 cycles after it first sees start, held until start drops.
   always @(posedge clk) begin
      if (!rst || !u_if.div_start_o) begin
         m_cnt             <= 0;
         u_if.div_ready_i  <= 1'b0;
      end else if (!u_if.div_ready_i && !m_never) begin
         if (m_cnt == 33) begin
            u_if.div_ready_i <= 1'b1;
            u_if.div_ret_i   <= ref_div(u_if.div_signed_o,
                                        u_if.div_opdata1_o,
                                        u_if.div_opdata2_o);
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue from IDLE, wait for the DONE cycle and check the result.
   task automatic run_div(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi,
                          input logic [31:0] e_lo, input string tag,
                          input bit hold);
      int  drops;
      int  tmos;
      bit  seen;
      check({tag, "_idle_start"}, u_if.div_start_o, 0);
      valid = 1'b1;
      sgn   = s;
      op1   = a;
      op2   = b;
      #1;
      check({tag, "_issue_stall"}, stall, 1);
      tick();
      check({tag, "_start"}, u_if.div_start_o, 1);
      check({tag, "_opdata1"}, u_if.div_opdata1_o, a);
      check({tag, "_signed"}, u_if.div_signed_o, s);
      drops = 0;
      tmos  = 0;
      seen  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tmo) tmos++;
         if (we) begin
            seen = 1'b1;
            break;
         end
         if (!stall) drops++;
      end
      check({tag, "_we"}, seen, 1);
      check({tag, "_stall_held"}, drops, 0);
      check({tag, "_no_tmo"}, tmos, 0);
      check({tag, "_done_stall"}, stall, 0);
      check({tag, "_hi"}, hi, e_hi);
      check({tag, "_lo"}, lo, e_lo);
      if (!hold) valid = 1'b0;
      tick();
      check({tag, "_we_pulse"}, we, 0);
   endtask

   initial begin
      int  cnt;
      int  wes;
      bit  seen;
      n_vec   = 0;
      n_err   = 0;
      m_never = 1'b0;
      rst     = 1'b0;
      valid   = 1'b1;
      sgn     = 1'b0;
      op1     = 32'd1;
      op2     = 32'd1;
      flush   = 1'b0;
      repeat (3) tick();
      check("rst_stall", stall, 0);
      check("rst_start", u_if.div_start_o, 0);
      check("rst_we", we, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_tmo", tmo, 0);
      valid = 1'b0;
      rst   = 1'b1;
      tick();

      run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "divu100_7", 1'b0);
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2,
              "div_m100_7", 1'b1);
      run_div(1'b0, 32'hFFFFFF9C, 32'd7, 32'd2, 32'h24924916,
              "divu_m100_7", 1'b0);
      run_div(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, "div5_0", 1'b0);

      // Flush ten cycles into BUSY.
      valid = 1'b1;
      sgn   = 1'b0;
      op1   = 32'd200;
      op2   = 32'd3;
      tick();
      repeat (10) tick();
      flush = 1'b1;
      #1;
      check("fl_annul", u_if.div_annul_o, 1);
      check("fl_we", we, 0);
      tick();
      check("fl_annul_idle", u_if.div_annul_o, 0);
      check("fl_start", u_if.div_start_o, 0);
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check("fl_stall", stall, 0);
      wes = 0;
      repeat (50) begin
         tick();
         if (we) wes++;
      end
      check("fl_no_write", wes, 0);
      run_div(1'b0, 32'd9, 32'd2, 32'd1, 32'd4, "divu9_2", 1'b0);

      // Flush on the same cycle the divider reports ready.
      valid = 1'b1;
      sgn   = 1'b1;
      op1   = 32'd50;
      op2   = 32'd5;
      tick();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (u_if.div_ready_i) begin
            seen = 1'b1;
            break;
         end
      end
      check("flr_ready_seen", seen, 1);
      flush = 1'b1;
      #1;
      check("flr_annul", u_if.div_annul_o, 1);
      tick();
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check("flr_we", we, 0);
      check("flr_stall", stall, 0);
      check("flr_lo_kept", lo, 4);

      // Flush during the DONE cycle.
      valid = 1'b1;
      sgn   = 1'b0;
      op1   = 32'd30;
      op2   = 32'd4;
      tick();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!stall) begin
            seen = 1'b1;
            break;
         end
      end
      check("fld_done_seen", seen, 1);
      flush = 1'b1;
      #1;
      check("fld_we", we, 0);
      check("fld_annul", u_if.div_annul_o, 0);
      tick();
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check("fld_we_after", we, 0);

      // Divider never answers: watchdog abort after 64 BUSY cycles.
      m_never = 1'b1;
      valid   = 1'b1;
      op1     = 32'd1;
      op2     = 32'd1;
      tick();
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         cnt++;
         if (tmo) begin
            seen = 1'b1;
            break;
         end
      end
      valid = 1'b0;
      #1;
      check("wd_seen", seen, 1);
      check("wd_cycles", cnt, 64);
      check("wd_stall", stall, 0);
      check("wd_we", we, 0);
      tick();
      check("wd_pulse", tmo, 0);
      m_never = 1'b0;

      // Reset in the middle of BUSY.
      valid = 1'b1;
      op1   = 32'd77;
      op2   = 32'd3;
      tick();
      repeat (5) tick();
      rst = 1'b0;
      tick();
      check("mr_stall", stall, 0);
      check("mr_start", u_if.div_start_o, 0);
      check("mr_op1", u_if.div_opdata1_o, 0);
      check("mr_we", we, 0);
      check("mr_hi", hi, 0);
      check("mr_lo", lo, 0);
      valid = 1'b0;
      rst   = 1'b1;
      tick();
      run_div(1'b0, 32'd9, 32'd2, 32'd1, 32'd4, "post_rst", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
